pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding and the default performance-counter width.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates memory wait, taken branch and
// load-use hazards into register enables/flushes and keeps perf counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(TIMEOUT_CYCLES);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_next;
    logic              mem_miss;
    logic              back_write;
    logic              branch_act;

    assign mem_miss  = dmem_req & ~dmem_ready;
    assign wait_next = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};

    // Wait counter advances with each un-ready MEM_WAIT cycle; hitting the limit latches FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_miss) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_next >= WAIT_LIMIT) begin
                        state    <= ST_FAULT;
                        wait_cnt <= wait_next[WAIT_W-1:0];
                    end else begin
                        wait_cnt <= wait_next[WAIT_W-1:0];
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        back_write  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        branch_act  = 1'b0;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    // Memory wait beats branch beats load-use; a miss leaves everything frozen.
                    if (!mem_miss) begin
                        if (branch_taken) begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                            back_write  = 1'b1;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                            branch_act  = 1'b1;
                        end else if (load_use) begin
                            back_write  = 1'b1;
                            id_ex_flush = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                            back_write  = 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        back_write  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign id_ex_write  = back_write;
    assign ex_mem_write = back_write;
    assign mem_wb_write = back_write;
    assign mem_timeout  = (state == ST_FAULT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .clr   (cnt_clr),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_act),
        .clr   (cnt_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_use = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, cnt_clr = 1'b0;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic          if_id_flush, id_ex_flush, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [7:0]    obs;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef enum {M_RUN, M_WAIT, M_FAULT} mode_t;
    mode_t m_mode  = M_RUN;
    int    m_wait  = 0;
    int    m_stall = 0;
    int    m_flush = 0;

    pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .cnt_clr      (cnt_clr),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .ex_mem_write (ex_mem_write),
        .mem_wb_write (mem_wb_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // {mem_timeout, pc, if_id, id_ex, ex_mem, mem_wb write, if_id_flush, id_ex_flush}
    assign obs = {mem_timeout, pc_write, if_id_write, id_ex_write, ex_mem_write,
                  mem_wb_write, if_id_flush, id_ex_flush};

    function automatic logic [7:0] model_ctrl();
        if (!rst_n) return 8'b0_00000_11;
        case (m_mode)
            M_FAULT: return 8'b1_00000_00;
            M_WAIT:  return dmem_ready ? 8'b0_11111_00 : 8'b0_00000_00;
            default: begin
                if (dmem_req && !dmem_ready) return 8'b0_00000_00;
                if (branch_taken)            return 8'b0_11111_11;
                if (load_use)                return 8'b0_00111_01;
                return 8'b0_11111_00;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = M_RUN;
        m_wait  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_tick();
        logic [7:0] c;
        logic       took_branch;
        c = model_ctrl();
        if (!rst_n) begin
            model_reset();
            return;
        end
        took_branch = (m_mode == M_RUN) && !(dmem_req && !dmem_ready) && branch_taken;
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!c[6] && m_stall < CMAX) m_stall++;
            if (took_branch && m_flush < CMAX) m_flush++;
        end
        case (m_mode)
            M_RUN: if (dmem_req && !dmem_ready) begin m_mode = M_WAIT; m_wait = 0; end
            M_WAIT: begin
                if (dmem_ready) begin
                    m_mode = M_RUN;
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= TO) m_mode = M_FAULT;
                end
            end
            default: m_mode = M_FAULT;
        endcase
    endtask

    task automatic set_in(input logic lu, input logic bt, input logic rq, input logic rd, input logic cc);
        load_use     = lu;
        branch_taken = bt;
        dmem_req     = rq;
        dmem_ready   = rd;
        cnt_clr      = cc;
    endtask

    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 8'b0_00000_11) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", obs, 8'b0_00000_11);
        end
        n_cmp++;
        if ({stall_cycles, flush_count} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: got %h expected 00", {stall_cycles, flush_count});
        end
        rst_n = 1'b1;
        #4;
        e = model_ctrl();
        n_cmp++;
        if (obs !== 8'b0_11111_00 || e !== 8'b0_11111_00) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs, 8'b0_11111_00);
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        set_in(0, 0, 0, 0, 1); #4; advance();
        set_in(1, 0, 0, 0, 0); #4;
        e = model_ctrl();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL load_use_ctrl: got %b expected %b", obs, e);
        end
        advance();
        set_in(0, 0, 0, 0, 0); #4;
        n_cmp++;
        if (obs !== 8'b0_11111_00) begin
            n_fail++;
            $display("[TB] FAIL load_use_release: got %b expected %b", obs, 8'b0_11111_00);
        end
        n_cmp++;
        if (stall_cycles !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stall_cycles);
        end
        advance();
    endtask

    task automatic test_branch_load_use();
        set_in(0, 0, 0, 0, 1); #4; advance();
        set_in(1, 1, 0, 0, 0); #4;
        n_cmp++;
        if (obs !== 8'b0_11111_11) begin
            n_fail++;
            $display("[TB] FAIL branch_lu_ctrl: got %b expected %b", obs, 8'b0_11111_11);
        end
        advance();
        set_in(0, 0, 0, 0, 0); #4;
        n_cmp++;
        if (flush_count !== 4'd1 || stall_cycles !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL branch_lu_counts: got flush=%0d stall=%0d expected flush=1 stall=0",
                     flush_count, stall_cycles);
        end
        advance();
    endtask

    task automatic test_mem_wait_branch();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'b0_00000_00, 8'b0_00000_00, 8'b0_00000_00, 8'b0_11111_00, 8'b0_11111_11};
        set_in(0, 0, 0, 0, 1); #4; advance();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 1, (i >= 3), 0); #4;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("[TB] FAIL mem_wait_branch_c%0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            advance();
        end
        set_in(0, 0, 0, 0, 0); #4;
        n_cmp++;
        if (stall_cycles !== 4'd3 || flush_count !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL mem_wait_branch_counts: got stall=%0d flush=%0d expected stall=3 flush=1",
                     stall_cycles, flush_count);
        end
        advance();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 1, 0, 0); #4;
            n_cmp++;
            if (mem_timeout !== (i >= 5)) begin
                n_fail++;
                $display("[TB] FAIL timeout_c%0d: got %b expected %b", i, mem_timeout, (i >= 5));
            end
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 1, 1, 0); #4;
            n_cmp++;
            if (obs !== 8'b1_00000_00) begin
                n_fail++;
                $display("[TB] FAIL timeout_sticky_c%0d: got %b expected %b", i, obs, 8'b1_00000_00);
            end
            advance();
        end
        set_in(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 8'b0_00000_11) begin
            n_fail++;
            $display("[TB] FAIL fault_async_reset: got %b expected %b", obs, 8'b0_00000_11);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #4;
        n_cmp++;
        if (obs !== 8'b0_11111_00) begin
            n_fail++;
            $display("[TB] FAIL fault_cleared: got %b expected %b", obs, 8'b0_11111_00);
        end
        advance();
        set_in(0, 0, 1, 0, 0); #4; advance();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 8'b0_00000_11) begin
            n_fail++;
            $display("[TB] FAIL wait_async_reset: got %b expected %b", obs, 8'b0_00000_11);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0); #4;
        n_cmp++;
        if (obs !== 8'b0_11111_00) begin
            n_fail++;
            $display("[TB] FAIL wait_abandoned: got %b expected %b", obs, 8'b0_11111_00);
        end
        advance();
    endtask

    task automatic test_saturation();
        int want;
        set_in(0, 0, 0, 0, 1); #4; advance();
        for (int k = 0; k < 20; k++) begin
            set_in(1, 0, 0, 0, 0); #4;
            want = (k > CMAX) ? CMAX : k;
            n_cmp++;
            if (stall_cycles !== want[CW-1:0]) begin
                n_fail++;
                $display("[TB] FAIL sat_stall_k%0d: got %0d expected %0d", k, stall_cycles, want);
            end
            advance();
        end
        set_in(1, 0, 0, 0, 1); #4;
        n_cmp++;
        if (stall_cycles !== 4'd15) begin
            n_fail++;
            $display("[TB] FAIL sat_stall_max: got %0d expected 15", stall_cycles);
        end
        advance();
        set_in(0, 0, 0, 0, 0); #4;
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL sat_clr_priority: got %0d expected 0", stall_cycles);
        end
        advance();
    endtask

    task automatic test_random();
        logic [7:0] e;
        int         fault_cycles;
        fault_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
                   ($urandom % 2) == 0, ($urandom % 16) == 0);
            if (($urandom % 60) == 0 || fault_cycles > 3) begin
                rst_n = 1'b0;
                model_reset();
                fault_cycles = 0;
            end else begin
                rst_n = 1'b1;
            end
            #4;
            e = model_ctrl();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("[TB] FAIL rand_ctrl_%0d: got %b expected %b", i, obs, e);
            end
            n_cmp++;
            if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
                n_fail++;
                $display("[TB] FAIL rand_counts_%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         i, stall_cycles, flush_count, m_stall, m_flush);
            end
            if (m_mode == M_FAULT) fault_cycles++;
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait_branch();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
